stream_burst_drain: RTL and testbench
=====================================

Name: stream_burst_drain

Overview:
- Read-side companion to the StreamingFIFO wrapper.
- Watches the FIFO occupancy (`count`) and pulls data from the FIFO output stream only in whole bursts of BURST_LEN beats.
- Forwards each burst downstream with TLAST on the final beat, as an AXI-Stream packet source for the IODMA / output DMA path.
- Residual data is flushed as a short packet on timeout or on an explicit flush request.

Parameters:
- DATA_W, 8, stream data width in bits.
- COUNT_W, 15, width of the FIFO occupancy input; covers 0..16384.
- BURST_LEN, 64, nominal packet length in beats; 1 <= BURST_LEN <= 2^COUNT_W-1.
- TIMEOUT, 1024, idle cycles with partial occupancy before a short packet is forced; must be >= 1.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- fifo_count  in  COUNT_W  occupancy from the upstream FIFO `count` output.
- in0_V_V_TDATA  in  DATA_W  FIFO output data.
- in0_V_V_TVALID  in  1  FIFO output valid.
- in0_V_V_TREADY  out  1  read strobe to the FIFO.
- out_V_V_TDATA  out  DATA_W  packet data.
- out_V_V_TVALID  out  1  packet valid.
- out_V_V_TREADY  in  1  downstream ready.
- out_V_V_TLAST  out  1  last beat of packet.
- flush  in  1  single-cycle request to emit the residual data now.
- busy  out  1  high while a burst is being read (state BURST).
- pkt_count  out  32  packets completed (TLAST beats accepted downstream); wraps at 2^32.

Behaviour:
- Interface (decided): single clock ap_clk; reset ap_rst is synchronous and active-high.
- Reset values:
  - in0_V_V_TREADY=0, out_V_V_TVALID=0, out_V_V_TLAST=0, out_V_V_TDATA=0.
  - busy=0, pkt_count=0.
  - FSM=IDLE; skid buffer empty; timeout counter=0; flush_pend=0.
- FSM state IDLE:
  - in0_V_V_TREADY=0.
  - If fifo_count >= BURST_LEN: latch len=BURST_LEN, go to BURST.
  - Else if fifo_count>0 and (tmo_cnt==TIMEOUT-1 or flush_pend or flush): latch len=fifo_count, go to BURST.
  - tmo_cnt increments while 0<fifo_count<BURST_LEN. It clears when fifo_count==0 and on entry to BURST.
  - flush while fifo_count==0: ignored, not latched.
  - flush arriving during BURST: sets flush_pend, cleared on the next entry to BURST.
- FSM state BURST:
  - in0_V_V_TREADY = skid-buffer input ready.
  - A beat is accepted when TVALID & TREADY; beat_cnt increments on each accepted beat.
  - The accepted beat is tagged last when beat_cnt==len-1.
  - On the last accept: beat_cnt=0, go to IDLE on the next cycle. The skid buffer drains independently.
  - fifo_count is ignored during BURST.
  - The snapshot len is always <= actual occupancy, because the FIFO only grows while IDLE. in0 TVALID low mid-burst simply stalls.
- Output stage (skid buffer):
  - 2-entry skid buffer; all out_* signals are registered.
  - Latency 1 cycle from input accept to out TVALID.
  - Sustains 1 beat/cycle with out TREADY held high.
  - in0_V_V_TREADY depends only on registered state, with no combinational path from out_V_V_TREADY.
  - out_V_V_TDATA and out_V_V_TLAST hold stable while TVALID & !TREADY.
- Throughput: back-to-back packets need one IDLE decision cycle between the last input accept of one burst and the first accept of the next.
- pkt_count increments by 1 on each cycle with out TVALID & TREADY & TLAST.
- Reset mid-burst: state is discarded immediately and no TLAST is emitted. Data already accepted into the skid buffer is lost.
- Width rules:
  - len and beat_cnt are COUNT_W bits.
  - tmo_cnt is clog2(TIMEOUT) bits, min 1.
  - Comparisons are unsigned.

Decomposition:
- Shared package: FSM state enum {IDLE, BURST}; helper function clog2_min1.
- Sub-module stream_skid_buf:
  - Params DATA_W+1 (data plus last), 2 entries.
  - Ports: ap_clk, ap_rst, i_d/i_v/i_r, o_d/o_v/o_r.
  - Reused elsewhere in the codebase for timing-closure register slices.

Test Plan:
- Full burst: fifo_count=64 with 64 continuous beats 0..63, out TREADY=1 -> 64 out beats in order, TLAST only on data 63, pkt_count=1, first out valid 2 cycles after count>=64.
- Timeout short packet: fifo_count=5 held, TIMEOUT=16 -> burst starts 16 cycles later, exactly 5 beats, TLAST on 5th, tmo_cnt back to 0.
- Flush: fifo_count=3, flush pulsed 1 cycle -> 3-beat packet starts next cycle. Flush with fifo_count=0 -> no activity, pkt_count unchanged.
- Backpressure: out TREADY toggled 1010... plus random 10-cycle lows during a 64-beat burst -> no beat lost, duplicated or reordered, out data/last stable while stalled, in0 TREADY low within 1 cycle once the skid is full.
- Back-to-back: fifo_count=200 -> three 64-beat packets with one idle cycle between input bursts, then an 8-beat packet after timeout; pkt_count=4.
- Reset mid-burst: ap_rst asserted at beat 20 of 64 -> next cycle all outputs 0, FSM IDLE; after release with count=64, a fresh complete packet is emitted.

Source files
------------

// File: rtl/stream_burst_drain_pkg.sv
// Shared types and helpers for the burst-drain read path.
//   drain_state_t : controller state (IDLE waits for a burst decision,
//                   BURST pulls beats from the FIFO into the output stage)
//   clog2_min1    : ceil(log2(n)) but never below 1, for counter widths
package stream_burst_drain_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } drain_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer / register slice.
//   ap_clk, ap_rst : clock, synchronous active-high reset
//   i_d, i_v, i_r  : upstream data / valid / ready
//   o_d, o_v, o_r  : downstream data / valid / ready
// All outputs are registered. i_r depends only on whether the skid entry
// is occupied, so there is no combinational path from o_r to i_r.
// Full throughput with o_r held high; o_d holds while o_v & !o_r.
module stream_skid_buf #(
  parameter int DATA_W = 9
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DATA_W-1:0] i_d,
  input  logic              i_v,
  output logic              i_r,
  output logic [DATA_W-1:0] o_d,
  output logic              o_v,
  input  logic              o_r
);

  // p0 = skid entry, p1 = output register
  logic [DATA_W-1:0] dat_p0;
  logic [DATA_W-1:0] dat_p1;
  logic              vld_p0;
  logic              vld_p1;
  logic              load_out;

  assign i_r      = !vld_p0;
  assign load_out = !vld_p1 || o_r;
  assign o_d      = dat_p1;
  assign o_v      = vld_p1;

  // Output register: refilled from the skid entry first, else from input.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      dat_p1 <= '0;
    end else begin
      if (load_out) begin
        if (vld_p0) begin
          vld_p1 <= 1'b1;
          dat_p1 <= dat_p0;
          vld_p0 <= 1'b0;
        end else begin
          vld_p1 <= i_v;
          if (i_v) dat_p1 <= i_d;
        end
      end else if (i_v && !vld_p0) begin
        vld_p0 <= 1'b1;
      end
    end
  end

  // Skid entry captures the beat that arrives while the output is stalled.
  always_ff @(posedge ap_clk) begin
    if (!load_out && i_v && !vld_p0) dat_p0 <= i_d;
  end

endmodule

// File: rtl/stream_burst_drain.sv
// Burst drain for a StreamingFIFO read side.
// Watches the FIFO occupancy and reads only whole bursts of BURST_LEN beats,
// forwarding each burst as an AXI-Stream packet with TLAST on its final beat.
// Residual data leaves as a short packet after TIMEOUT idle cycles with
// partial occupancy, or immediately on a flush request.
//   ap_clk, ap_rst        : clock, synchronous active-high reset
//   fifo_count            : upstream FIFO occupancy
//   in0_V_V_T{DATA,VALID,READY} : FIFO output stream (READY = read strobe)
//   out_V_V_T{DATA,VALID,READY,LAST} : packet stream towards the DMA
//   flush                 : single-cycle request to emit residual data
//   busy                  : high while a burst is being read
//   pkt_count             : packets accepted downstream (wraps)
module stream_burst_drain
  import stream_burst_drain_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int COUNT_W   = 15,
  parameter int BURST_LEN = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [COUNT_W-1:0] fifo_count,
  input  logic [DATA_W-1:0]  in0_V_V_TDATA,
  input  logic               in0_V_V_TVALID,
  output logic               in0_V_V_TREADY,
  output logic [DATA_W-1:0]  out_V_V_TDATA,
  output logic               out_V_V_TVALID,
  input  logic               out_V_V_TREADY,
  output logic               out_V_V_TLAST,
  input  logic               flush,
  output logic               busy,
  output logic [31:0]        pkt_count
);

  localparam int                 TMO_W      = clog2_min1(TIMEOUT);
  localparam logic [COUNT_W-1:0] BURST_LEN_C = COUNT_W'(BURST_LEN);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);

  drain_state_t       state;
  logic [COUNT_W-1:0] len;
  logic [COUNT_W-1:0] beat_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               flush_pend;
  logic               skid_i_r;
  logic               skid_i_v;
  logic               in_acc;
  logic               last_beat;
  logic               has_data;
  logic               full_ready;
  logic               short_go;

  assign skid_i_v       = in0_V_V_TVALID && (state == BURST);
  assign in0_V_V_TREADY = (state == BURST) && skid_i_r;
  assign in_acc         = in0_V_V_TVALID && in0_V_V_TREADY;
  assign last_beat      = (beat_cnt == len - COUNT_W'(1));
  assign busy           = (state == BURST);

  assign has_data   = (fifo_count != '0);
  assign full_ready = (fifo_count >= BURST_LEN_C);
  // A pending or live flush only forces a short packet when there is data.
  assign short_go   = has_data && ((tmo_cnt == TMO_LAST) || flush_pend || flush);

  // Decision / read stage
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state      <= IDLE;
      len        <= '0;
      beat_cnt   <= '0;
      tmo_cnt    <= '0;
      flush_pend <= 1'b0;
      pkt_count  <= '0;
    end else begin
      if (out_V_V_TVALID && out_V_V_TREADY && out_V_V_TLAST)
        pkt_count <= pkt_count + 32'd1;

      case (state)
        IDLE: begin
          if (full_ready || short_go) begin
            // Snapshot is safe: the FIFO can only grow while we are idle.
            len        <= full_ready ? BURST_LEN_C : fifo_count;
            state      <= BURST;
            beat_cnt   <= '0;
            tmo_cnt    <= '0;
            flush_pend <= 1'b0;
          end else if (has_data) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end else begin
            tmo_cnt <= '0;
          end
        end
        BURST: begin
          if (flush) flush_pend <= 1'b1;
          if (in_acc) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + COUNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: last flag travels with the data through the slice
  stream_skid_buf #(
    .DATA_W(DATA_W + 1)
  ) u_skid (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .i_d    ({last_beat, in0_V_V_TDATA}),
    .i_v    (skid_i_v),
    .i_r    (skid_i_r),
    .o_d    ({out_V_V_TLAST, out_V_V_TDATA}),
    .o_v    (out_V_V_TVALID),
    .o_r    (out_V_V_TREADY)
  );

endmodule

// File: tb/tb_stream_burst_drain.sv
// Randomized bench for stream_burst_drain with a queue-based FIFO and a
// packet-level reference: all pushed data must come out in order, and a
// block of N words pushed at once must leave as floor(N/64) full packets
// plus one short packet of the remainder.
module tb_stream_burst_drain;

  localparam int DATA_W    = 8;
  localparam int COUNT_W   = 15;
  localparam int BURST_LEN = 64;
  localparam int TIMEOUT   = 16;

  logic               ap_clk;
  logic               ap_rst;
  logic [COUNT_W-1:0] fifo_count;
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               flush;
  logic               busy;
  logic [31:0]        pkt_count;

  stream_burst_drain #(
    .DATA_W(DATA_W), .COUNT_W(COUNT_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .fifo_count     (fifo_count),
    .in0_V_V_TDATA  (in_data),
    .in0_V_V_TVALID (in_valid),
    .in0_V_V_TREADY (in_ready),
    .out_V_V_TDATA  (out_data),
    .out_V_V_TVALID (out_valid),
    .out_V_V_TREADY (out_ready),
    .out_V_V_TLAST  (out_last),
    .flush          (flush),
    .busy           (busy),
    .pkt_count      (pkt_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int          got_lens[$];
  int          got_start[$];
  int          got_end[$];
  int          exp_lens[$];
  int          cur_len   = 0;
  int          cyc       = 0;
  int          inflight  = 0;
  int          rdy_mode  = 0;
  int          low_run   = 0;
  bit          gap_en    = 0;
  bit          track     = 0;
  bit          prev_stall = 0;
  logic [DATA_W-1:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic [31:0] pkt_model = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int start_at(input int i);
    if (i < got_start.size()) return got_start[i];
    return -100000;
  endfunction

  function automatic int end_at(input int i);
    if (i < got_end.size()) return got_end[i];
    return 100000;
  endfunction

  task automatic drive();
    fifo_count = COUNT_W'(fifo_q.size());
    in_valid   = (fifo_q.size() > 0) && (!gap_en || ($urandom_range(0, 3) != 0));
    in_data    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    flush      = 1'b0;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        if (low_run > 0) begin
          low_run--;
          out_ready = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          low_run   = 9;
          out_ready = 1'b0;
        end else begin
          out_ready = cyc[0];
        end
      end
      default: out_ready = ($urandom_range(0, 1) == 1);
    endcase
  endtask

  // One clock: observe at the falling edge, update the FIFO model and
  // drive new inputs just after the rising edge.
  task automatic step();
    logic in_acc;
    logic [DATA_W-1:0] e;
    @(negedge ap_clk);
    in_acc = 1'b0;
    if (track) begin
      chk("pkt_count", pkt_count, pkt_model);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("data", out_data, e);
        end
        if (cur_len == 0) got_start.push_back(cyc);
        cur_len++;
        inflight--;
        if (out_last) begin
          got_lens.push_back(cur_len);
          got_end.push_back(cyc);
          cur_len = 0;
          pkt_model = pkt_model + 32'd1;
        end
      end
      in_acc = in_valid && in_ready;
      if (in_acc) inflight++;
      chk("inflight_le2", (inflight <= 2), 1'b1);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge ap_clk);
    #1;
    cyc++;
    if (in_acc) void'(fifo_q.pop_front());
    drive();
  endtask

  task automatic push_n(input int n, input bit seq);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = seq ? DATA_W'(i) : DATA_W'($urandom_range(0, 255));
      fifo_q.push_back(v);
      exp_q.push_back(v);
    end
    fifo_count = COUNT_W'(fifo_q.size());
    in_valid   = (fifo_q.size() > 0);
    in_data    = fifo_q[0];
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
    repeat (3) step();
  endtask

  task automatic set_exp(input int n);
    int r;
    r = n;
    exp_lens.delete();
    while (r >= BURST_LEN) begin
      exp_lens.push_back(BURST_LEN);
      r -= BURST_LEN;
    end
    if (r > 0) exp_lens.push_back(r);
  endtask

  task automatic check_pkts(input string tag);
    chk({tag, "_npkts"}, got_lens.size(), exp_lens.size());
    for (int i = 0; i < exp_lens.size() && i < got_lens.size(); i++)
      chk({tag, "_len"}, got_lens[i], exp_lens[i]);
  endtask

  task automatic clear_pkts();
    got_lens.delete();
    got_start.delete();
    got_end.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    logic [31:0] base;

    ap_rst = 1'b1; flush = 1'b0; fifo_count = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1; track = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pkt_count", pkt_count, 0);
    ap_rst = 1'b0;
    track  = 1'b1;
    repeat (3) step();

    // Full burst, data 0..63
    rdy_mode = 0; gap_en = 0;
    push_n(64, 1'b1);
    c = cyc;
    step();
    chk("full_busy", busy, 1'b1);
    drain(2000);
    set_exp(64); check_pkts("full");
    chk("full_lat", start_at(0) - c, 2);
    chk("full_pktcnt", pkt_count, 1);
    clear_pkts();

    // Timeout short packet
    push_n(5, 1'b0);
    c = cyc;
    drain(2000);
    set_exp(5); check_pkts("tmo");
    chk("tmo_lat", start_at(0) - c, TIMEOUT + 1);
    clear_pkts();

    // Flush with residual data
    push_n(3, 1'b0);
    flush = 1'b1;
    c = cyc;
    drain(2000);
    set_exp(3); check_pkts("flush");
    chk("flush_lat", start_at(0) - c, 2);
    clear_pkts();

    // Flush with empty FIFO is ignored and not remembered
    base = pkt_count;
    flush = 1'b1;
    repeat (30) step();
    chk("eflush_npkts", got_lens.size(), 0);
    chk("eflush_pktcnt", pkt_count, base);
    chk("eflush_busy", busy, 1'b0);
    push_n(3, 1'b0);
    c = cyc;
    drain(2000);
    set_exp(3); check_pkts("eflush_after");
    chk("eflush_after_lat", start_at(0) - c, TIMEOUT + 1);
    clear_pkts();

    // Flush during a burst flushes the residual right after it
    push_n(70, 1'b0);
    repeat (5) step();
    flush = 1'b1;
    drain(2000);
    set_exp(70); check_pkts("pend");
    chk("pend_gap", start_at(1) - end_at(0), 2);
    clear_pkts();

    // Backpressure: alternating ready plus random 10-cycle lows
    rdy_mode = 1;
    push_n(64, 1'b0);
    drain(3000);
    set_exp(64); check_pkts("bp");
    clear_pkts();

    // Back-to-back bursts then a timed-out remainder
    rdy_mode = 0;
    base = pkt_count;
    push_n(200, 1'b0);
    c = cyc;
    drain(3000);
    set_exp(200); check_pkts("b2b");
    chk("b2b_lat", start_at(0) - c, 2);
    chk("b2b_gap1", start_at(1) - end_at(0), 2);
    chk("b2b_gap2", start_at(2) - end_at(1), 2);
    chk("b2b_gap3", start_at(3) - end_at(2), TIMEOUT + 1);
    chk("b2b_pktcnt", pkt_count - base, 4);
    clear_pkts();

    // Random blocks with random ready and input gaps
    for (int it = 0; it < 6; it++) begin
      rdy_mode = $urandom_range(1, 2);
      gap_en   = ($urandom_range(0, 1) == 1);
      n        = $urandom_range(1, 160);
      push_n(n, 1'b0);
      drain(6000);
      set_exp(n); check_pkts("rand");
      clear_pkts();
    end

    // Reset in the middle of a burst
    rdy_mode = 0; gap_en = 0;
    push_n(64, 1'b1);
    n = 0;
    while (cur_len < 20 && n < 300) begin
      step();
      n++;
    end
    chk("mid_reached", cur_len, 20);
    ap_rst = 1'b1;
    track  = 1'b0;
    step();
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_last", out_last, 1'b0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_pktcnt", pkt_count, 0);
    ap_rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    cur_len = 0; inflight = 0; pkt_model = '0;
    clear_pkts();
    drive();
    track = 1'b1;
    repeat (2) step();
    chk("mid_idle_busy", busy, 1'b0);
    push_n(64, 1'b1);
    c = cyc;
    drain(2000);
    set_exp(64); check_pkts("mid_after");
    chk("mid_after_lat", start_at(0) - c, 2);
    chk("mid_after_pktcnt", pkt_count, 1);
    clear_pkts();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
